vga_timing_recovery: RTL and testbench
======================================

// Module: vga_timing_recovery
// PURPOSE
//  Sink-side counterpart of the VGA timing generator: consumes a sync/blank/pixel stream
//  of the kind vga_controller and the pixel register stage produce, all on the same clock.
//  Measures line and frame geometry, recovers display_col/display_row for every visible
//  pixel and flags lock once two consecutive frames agree. Used for loopback checking and
//  for capturing frames into downstream logic.
// PARAMETERS
//  COL_W      12     width of column counters and horizontal measurements
//  ROW_W      11     width of row counters and vertical measurements
//  LINE_TMO   4095   cycles without an hsync falling edge before lock is dropped
// PORTS
//  clock        in   1      pixel clock; all logic on rising edge
//  reset        in   1      synchronous, active-low; 0 = reset
//  in_hs        in   1      hsync, active-low pulse
//  in_vs        in   1      vsync, active-low pulse
//  in_blank_n   in   1      1 = visible pixel this cycle
//  in_color     in   24     {R[23:16],G[15:8],B[7:0]}
//  display_col  out  COL_W  column of pix_color, 0-based within the visible area
//  display_row  out  ROW_W  row of pix_color, 0-based within the visible area
//  pix_valid    out  1      pix_color/col/row hold a visible pixel
//  pix_color    out  24     registered copy of in_color
//  frame_start  out  1      1-cycle pulse with the pixel at col 0, row 0
//  h_total      out  COL_W  last measured cycles per line, minus 1
//  v_total      out  ROW_W  last measured lines per frame, minus 1
//  h_active     out  COL_W  visible pixels in the last line
//  v_active     out  ROW_W  lines with >=1 visible pixel in the last frame
//  locked       out  1      geometry stable; pix_* trustworthy
// BEHAVIOUR
//  Reset (reset==0 on a rising edge): every output 0, state SEARCH, all counters 0.
//  Inputs are registered once (s_*), then once more (d_*) for edge detection.
//  Edges:
//   - hs_fall = d_hs & ~s_hs; vs_fall = d_vs & ~s_vs; bl_rise = ~d_blank & s_blank.
//  Horizontal:
//   - hcnt increments every cycle. On hs_fall: h_total <= hcnt, hcnt <= 0.
//   - On hs_fall the visible-count register is also copied to h_active and then cleared.
//   - hcnt saturates at all-ones; no wrap.
//  Vertical:
//   - vcnt increments on each hs_fall. On vs_fall: v_total <= vcnt, vcnt <= 0.
//   - On vs_fall the lines-with-visible count is copied to v_active and cleared.
//   - hs_fall and vs_fall in the same cycle: apply the hs update first, then the vs
//     update, so vcnt ends at 0.
//  Pixel path, latency 2 cycles from in_* to pix_*:
//   - pix_valid <= s_blank; pix_color <= s_color.
//   - col: cleared on bl_rise, else +1 on each visible cycle.
//   - row: cleared on the first bl_rise after vs_fall, +1 on each later bl_rise.
//   - display_col/row are registered with pix_*. They hold their value when pix_valid==0.
//   - frame_start = pix_valid & col==0 & row==0, and only while locked==1.
//  Lock FSM:
//   - SEARCH -> MEAS1 on vs_fall: snapshot h_total, v_total, h_active, v_active.
//   - MEAS1 -> LOCKED on the next vs_fall if all four match the snapshot. On any mismatch
//     stay in MEAS1 and take a new snapshot.
//   - LOCKED -> SEARCH on any of:
//       a vs_fall whose geometry differs from the snapshot;
//       an hs_fall whose new h_total differs from the snapshot;
//       hcnt reaching LINE_TMO.
//   - locked = (state==LOCKED), registered. It drops the cycle after the cause.
//   - Measurement outputs keep updating in every state.
//  A low reset mid-frame discards all partial counts. Lock needs 2 full frames again.
// TESTING
//  - 1280x1024 stream (H 1688, V 1066, active 1280x1024): h_total=1687, v_total=1065,
//    h_active=1280, v_active=1024; locked=1 at the third vs_fall after reset release.
//  - Locked stream: first visible pixel of a frame -> frame_start=1 with col=0, row=0,
//    2 cycles after in_blank_n rises; last pixel -> col=1279, row=1023, pix_color==input.
//  - Locked, one line lengthened to 1689 cycles -> locked=0 one cycle after that hs_fall;
//    relock after 2 clean frames.
//  - Locked, hsync held high for 4095 cycles -> locked=0; h_total holds its previous value.
//  - hs and vs falling in the same cycle -> vcnt=0, v_total=previous line count;
//    no spurious row increment.
//  - reset=0 for 1 cycle mid-frame -> all outputs 0 next cycle; measurements valid again
//    after the next complete frame.

Source files
------------

// File: rtl/vga_timing_recovery.sv
// Sink-side VGA timing recovery: measures line/frame geometry from an hs/vs/blank stream,
// recovers display coordinates of each visible pixel and reports lock after two matching frames.
module vga_timing_recovery #(
  parameter int COL_W    = 12,
  parameter int ROW_W    = 11,
  parameter int LINE_TMO = 4095
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic             in_blank_n,
  input  logic [23:0]      in_color,
  output logic [COL_W-1:0] display_col,
  output logic [ROW_W-1:0] display_row,
  output logic             pix_valid,
  output logic [23:0]      pix_color,
  output logic             frame_start,
  output logic [COL_W-1:0] h_total,
  output logic [ROW_W-1:0] v_total,
  output logic [COL_W-1:0] h_active,
  output logic [ROW_W-1:0] v_active,
  output logic             locked,
  output logic [1:0]       lock_state
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEAS1 = 2'd1, LOCKED = 2'd2} lock_state_e;

  logic             s_hs_q, s_vs_q, s_blank_q, d_hs_q, d_vs_q, d_blank_q;
  logic [23:0]      s_color_q;
  logic             hs_fall, vs_fall, bl_rise;

  logic [COL_W-1:0] hcnt_q, hcnt_d, vis_q, vis_d;
  logic [COL_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [ROW_W-1:0] vcnt_q, vcnt_d, vlines_q, vlines_d;
  logic [ROW_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic             line_vis_q, line_vis_d;

  logic             pix_valid_q;
  logic [23:0]      pix_color_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             first_q, first_d;

  lock_state_e      state_q, state_d;
  logic [COL_W-1:0] snap_h_q, snap_h_d, snap_ha_q, snap_ha_d;
  logic [ROW_W-1:0] snap_v_q, snap_v_d, snap_va_q, snap_va_d;
  logic             geom_match, tmo_hit;

  assign hs_fall = d_hs_q & ~s_hs_q;
  assign vs_fall = d_vs_q & ~s_vs_q;
  assign bl_rise = ~d_blank_q & s_blank_q;

  always_comb begin
    hcnt_d     = (hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1;
    h_total_d  = h_total_q;
    h_active_d = h_active_q;
    vis_d      = s_blank_q ? vis_q + 1'b1 : vis_q;
    if (hs_fall) begin
      h_total_d  = hcnt_q;
      hcnt_d     = '0;
      h_active_d = vis_q;
      vis_d      = {{(COL_W-1){1'b0}}, s_blank_q};
    end
  end

  // A vs edge arrives together with the hs edge that opens its line, so v_total takes the
  // line count accumulated before that edge and the new frame restarts at 0.
  always_comb begin
    vcnt_d     = hs_fall ? vcnt_q + 1'b1 : vcnt_q;
    v_total_d  = v_total_q;
    v_active_d = v_active_q;
    vlines_d   = vlines_q;
    line_vis_d = line_vis_q & ~hs_fall;
    if (vs_fall) begin
      v_total_d  = vcnt_q;
      vcnt_d     = '0;
      v_active_d = vlines_q;
      vlines_d   = '0;
    end
    if (s_blank_q && !line_vis_d) begin
      vlines_d   = vlines_d + 1'b1;
      line_vis_d = 1'b1;
    end
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    first_d = first_q;
    if (vs_fall) first_d = 1'b1;
    if (bl_rise) begin
      col_d = '0;
      if (first_d) begin
        row_d   = '0;
        first_d = 1'b0;
      end else begin
        row_d = row_q + 1'b1;
      end
    end else if (s_blank_q) begin
      col_d = col_q + 1'b1;
    end
  end

  assign geom_match = (h_total_d == snap_h_q) && (v_total_d == snap_v_q) &&
                      (h_active_d == snap_ha_q) && (v_active_d == snap_va_q);
  assign tmo_hit    = (hcnt_q == COL_W'(LINE_TMO));

  always_comb begin
    state_d   = state_q;
    snap_h_d  = snap_h_q;
    snap_v_d  = snap_v_q;
    snap_ha_d = snap_ha_q;
    snap_va_d = snap_va_q;
    case (state_q)
      SEARCH, MEAS1: begin
        if (vs_fall) begin
          if (state_q == MEAS1 && geom_match) begin
            state_d = LOCKED;
          end else begin
            state_d   = MEAS1;
            snap_h_d  = h_total_d;
            snap_v_d  = v_total_d;
            snap_ha_d = h_active_d;
            snap_va_d = v_active_d;
          end
        end
      end
      LOCKED: begin
        if ((vs_fall && !geom_match) || (hs_fall && h_total_d != snap_h_q) || tmo_hit)
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s_hs_q      <= 1'b0;
      s_vs_q      <= 1'b0;
      s_blank_q   <= 1'b0;
      s_color_q   <= '0;
      d_hs_q      <= 1'b0;
      d_vs_q      <= 1'b0;
      d_blank_q   <= 1'b0;
      hcnt_q      <= '0;
      vis_q       <= '0;
      h_total_q   <= '0;
      h_active_q  <= '0;
      vcnt_q      <= '0;
      vlines_q    <= '0;
      v_total_q   <= '0;
      v_active_q  <= '0;
      line_vis_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      first_q     <= 1'b0;
      state_q     <= SEARCH;
      snap_h_q    <= '0;
      snap_v_q    <= '0;
      snap_ha_q   <= '0;
      snap_va_q   <= '0;
    end else begin
      s_hs_q      <= in_hs;
      s_vs_q      <= in_vs;
      s_blank_q   <= in_blank_n;
      s_color_q   <= in_color;
      d_hs_q      <= s_hs_q;
      d_vs_q      <= s_vs_q;
      d_blank_q   <= s_blank_q;
      hcnt_q      <= hcnt_d;
      vis_q       <= vis_d;
      h_total_q   <= h_total_d;
      h_active_q  <= h_active_d;
      vcnt_q      <= vcnt_d;
      vlines_q    <= vlines_d;
      v_total_q   <= v_total_d;
      v_active_q  <= v_active_d;
      line_vis_q  <= line_vis_d;
      pix_valid_q <= s_blank_q;
      pix_color_q <= s_color_q;
      col_q       <= col_d;
      row_q       <= row_d;
      first_q     <= first_d;
      state_q     <= state_d;
      snap_h_q    <= snap_h_d;
      snap_v_q    <= snap_v_d;
      snap_ha_q   <= snap_ha_d;
      snap_va_q   <= snap_va_d;
    end
  end

  assign display_col = col_q;
  assign display_row = row_q;
  assign pix_valid   = pix_valid_q;
  assign pix_color   = pix_color_q;
  assign frame_start = pix_valid_q && (col_q == '0) && (row_q == '0) && (state_q == LOCKED);
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign h_active    = h_active_q;
  assign v_active    = v_active_q;
  assign locked      = (state_q == LOCKED);
  assign lock_state  = state_q;

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Bench for vga_timing_recovery: random-geometry frame streams with long-line, timeout and
// mid-frame reset episodes; a frame-level reference model feeds a pixel scoreboard.
module tb_vga_timing_recovery;
  localparam int COL_W    = 12;
  localparam int ROW_W    = 11;
  localparam int LINE_TMO = 4095;
  localparam int EW       = 2 + ROW_W + COL_W + 24;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_hs = 1'b1, in_vs = 1'b1, in_blank_n = 1'b0;
  logic [23:0]      in_color = '0;
  logic [COL_W-1:0] display_col, h_total, h_active;
  logic [ROW_W-1:0] display_row, v_total, v_active;
  logic             pix_valid, frame_start, locked;
  logic [23:0]      pix_color;
  logic [1:0]       lock_state;

  vga_timing_recovery #(.COL_W(COL_W), .ROW_W(ROW_W), .LINE_TMO(LINE_TMO)) dut (
    .clock(clock), .reset(reset), .in_hs(in_hs), .in_vs(in_vs), .in_blank_n(in_blank_n),
    .in_color(in_color), .display_col(display_col), .display_row(display_row),
    .pix_valid(pix_valid), .pix_color(pix_color), .frame_start(frame_start),
    .h_total(h_total), .v_total(v_total), .h_active(h_active), .v_active(v_active),
    .locked(locked), .lock_state(lock_state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  int HSW = 4, HBP, HA, HFP, H, VSW = 2, VBP, VA, VFP, V;

  // Reference model: measurements, frame-level lock decision and pixel coordinates.
  int   m_len, m_vis, m_vcnt, m_vlines, m_row;
  int   m_htot, m_vtot, m_hact, m_vact;
  int   m_state;  // 0 searching, 1 one frame measured, 2 locked
  int   s_h, s_v, s_ha, s_va;
  bit   m_line_vis, m_row_first, chk_zero_pending;
  logic m_prev_hs, m_prev_vs, m_prev_bl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_len = 1; m_vis = 0; m_vcnt = 0; m_vlines = 0; m_row = 0;
    m_htot = 0; m_vtot = 0; m_hact = 0; m_vact = 0; m_state = 0;
    s_h = 0; s_v = 0; s_ha = 0; s_va = 0;
    m_line_vis = 0; m_row_first = 0;
    m_prev_hs = 0; m_prev_vs = 0; m_prev_bl = 0;
  endtask

  task automatic check_zero();
    chk("rst_col", display_col, 0);   chk("rst_row", display_row, 0);
    chk("rst_valid", pix_valid, 0);   chk("rst_color", pix_color, 0);
    chk("rst_fs", frame_start, 0);    chk("rst_htot", h_total, 0);
    chk("rst_vtot", v_total, 0);      chk("rst_hact", h_active, 0);
    chk("rst_vact", v_active, 0);     chk("rst_locked", locked, 0);
  endtask

  task automatic check_meas();
    chk("h_total", h_total, m_htot);
    chk("v_total", v_total, m_vtot);
    chk("h_active", h_active, m_hact);
    chk("v_active", v_active, m_vact);
    chk("locked", locked, (m_state == 2));
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 0; in_hs = 1; in_vs = 1; in_blank_n = 0;
    repeat (n - 1) @(negedge clock);
    model_reset();
    chk_zero_pending = 1;
  endtask

  task automatic drive_cycle(input logic hs, input logic vs, input logic bl, input int pcol);
    logic [23:0] c;
    bit hf, vf, br, geo_eq, lk, fs;
    @(negedge clock);
    if (chk_zero_pending) begin
      check_zero();
      reset = 1;
      chk_zero_pending = 0;
    end
    c = 24'($urandom);
    in_hs = hs; in_vs = vs; in_blank_n = bl; in_color = c;

    m_len++;
    hf = m_prev_hs & ~hs;
    vf = m_prev_vs & ~vs;
    br = ~m_prev_bl & bl;
    m_prev_hs = hs; m_prev_vs = vs; m_prev_bl = bl;
    if (hf) begin
      m_htot = (m_len - 1 > 4095) ? 4095 : m_len - 1;
      m_len = 0;
      m_hact = m_vis;
      m_vis = 0;
      m_line_vis = 0;
      if (!vf) m_vcnt++;
    end
    if (vf) begin
      m_vtot = m_vcnt; m_vcnt = 0;
      m_vact = m_vlines; m_vlines = 0;
      m_row_first = 1;
    end
    if (bl) begin
      m_vis++;
      if (!m_line_vis) begin m_line_vis = 1; m_vlines++; end
    end
    if (br) begin
      if (m_row_first) begin m_row = 0; m_row_first = 0; end
      else m_row++;
    end

    geo_eq = (m_htot == s_h) && (m_vtot == s_v) && (m_hact == s_ha) && (m_vact == s_va);
    if (m_state == 2) begin
      if ((hf && m_htot != s_h) || (vf && !geo_eq)) m_state = 0;
    end else if (vf) begin
      if (m_state == 1 && geo_eq) m_state = 2;
      else begin
        s_h = m_htot; s_v = m_vtot; s_ha = m_hact; s_va = m_vact; m_state = 1;
      end
    end
    if (m_state == 2 && m_len >= LINE_TMO + 1) m_state = 0;

    if (bl) begin
      lk = (m_state == 2);
      fs = lk && (m_row == 0) && (pcol == 0);
      exp_q.push_back({lk, fs, ROW_W'(m_row), COL_W'(pcol), c});
    end
  endtask

  task automatic run_frame(input int long_line, input int rst_line);
    for (int v = 0; v < V; v++) begin
      int len;
      len = (v == long_line) ? H + 1 : H;
      for (int h = 0; h < len; h++) begin
        bit vis;
        if (h == 3) check_meas();
        vis = (v >= VBP) && (v < VBP + VA) && (h >= HBP) && (h < HBP + HA);
        if (v == rst_line && h == H - 2) do_reset(1);
        else drive_cycle(h >= HSW, v >= VSW, vis, h - HBP);
      end
    end
  endtask

  // Scoreboard monitor: every visible pixel the DUT presents is matched against the queue.
  initial begin
    logic [EW-1:0] got, exp;
    forever begin
      @(negedge clock);
      if (reset && pix_valid) begin
        got = {locked, frame_start, display_row, display_col, pix_color};
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pixel_unexpected: got %0h expected none at %0t", got, $time);
        end else begin
          exp = exp_q.pop_front();
          chk("pixel", got, exp);
        end
      end
    end
  end

  initial begin
    HBP = $urandom_range(6, 8);  HA = $urandom_range(12, 24); HFP = $urandom_range(3, 6);
    H   = HBP + HA + HFP;
    VBP = $urandom_range(3, 4);  VA = $urandom_range(6, 10);  VFP = $urandom_range(2, 3);
    V   = VBP + VA + VFP;
    chk_zero_pending = 0;
    model_reset();

    do_reset(3);
    repeat (10) drive_cycle(1, 1, 0, 0);

    for (int f = 0; f < 4; f++) run_frame(-1, -1);
    run_frame(VBP + 2, -1);
    for (int f = 0; f < 3; f++) run_frame(-1, -1);

    repeat (4200) drive_cycle(1, 1, 0, 0);
    check_meas();

    run_frame(-1, -1);
    run_frame(-1, -1);
    run_frame(-1, VBP + VA / 2);
    for (int f = 0; f < 4; f++) run_frame(-1, -1);

    repeat (5) drive_cycle(1, 1, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
